debounce_bank: RTL

Parametrised multi-channel push-button conditioner for the parking controller's entry/exit/call buttons. Each channel has three stages: a two-flop synchroniser, a per-channel debounce state machine and a long-press detector. Each channel produces a clean level, single-cycle press and release pulses, and a one-shot long-press pulse. It replaces the single-input debouncer for all panel buttons.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_channel.sv | 133 +++++++++++++
 rtl/debounce_bank.sv | 39 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the push-button debounce bank.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } debState_t;

  // Bits needed to hold values 0..maxVal without wrapping.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, debounce FSM, long-press detector.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 1000
) (
  input  logic clk,
  input  logic rstN,
  input  logic button,
  output logic level,
  output logic pressPulse,
  output logic releasePulse,
  output logic longPress
);

  localparam int CNT_W  = cntWidth(STABLE_CYCLES);
  localparam int HOLD_W = cntWidth(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam bit SINGLE = (STABLE_CYCLES == 1);

  logic sync1, syncB;
  debState_t state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt;
  logic [HOLD_W-1:0] holdCnt, nextHold;
  logic fired, nextFired;
  logic fire, isHigh;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1 <= 1'b0;
      syncB <= 1'b0;
    end else begin
      sync1 <= button;
      syncB <= sync1;
    end
  end

  // fired latches after the long-press pulse so a saturated holdCnt cannot re-trigger it.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    nextHold  = holdCnt;
    fire      = (holdCnt == HOLD_MAX) && !fired;
    nextFired = fired | fire;
    case (state)
      LOW: begin
        if (syncB) begin
          if (SINGLE) begin
            nextState = HIGH;
            nextCnt   = '0;
          end else begin
            nextState = CHK_HIGH;
            nextCnt   = CNT_ONE;
          end
        end
      end
      CHK_HIGH: begin
        if (!syncB) begin
          nextState = LOW;
          nextCnt   = '0;
        end else if (cnt == CNT_LAST) begin
          nextState = HIGH;
          nextCnt   = '0;
        end else begin
          nextCnt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        if (holdCnt != HOLD_MAX) nextHold = holdCnt + HOLD_ONE;
        if (!syncB) begin
          if (SINGLE) begin
            nextState = LOW;
            nextCnt   = '0;
            nextHold  = '0;
            nextFired = 1'b0;
          end else begin
            nextState = CHK_LOW;
            nextCnt   = CNT_ONE;
          end
        end
      end
      CHK_LOW: begin
        if (syncB) begin
          nextState = HIGH;
          nextCnt   = '0;
        end else if (cnt == CNT_LAST) begin
          nextState = LOW;
          nextCnt   = '0;
          nextHold  = '0;
          nextFired = 1'b0;
        end else begin
          nextCnt = cnt + CNT_ONE;
        end
      end
      default: begin
        nextState = LOW;
        nextCnt   = '0;
        nextHold  = '0;
        nextFired = 1'b0;
      end
    endcase
  end

  assign isHigh = (state == HIGH) || (state == CHK_LOW);

  // Outputs are registered from the current state so level and pulses change together.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state        <= LOW;
      cnt          <= '0;
      holdCnt      <= '0;
      fired        <= 1'b0;
      level        <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      longPress    <= 1'b0;
    end else begin
      state        <= nextState;
      cnt          <= nextCnt;
      holdCnt      <= nextHold;
      fired        <= nextFired;
      level        <= isHigh;
      pressPulse   <= isHigh & ~level;
      releasePulse <= ~isHigh & level;
      longPress    <= fire;
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button conditioner: one debounce_channel per input plus a registered any-active flag.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES   = 1000
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic [CHANNELS-1:0] inButton,
  output logic [CHANNELS-1:0] outButton,
  output logic [CHANNELS-1:0] pressPulse,
  output logic [CHANNELS-1:0] releasePulse,
  output logic [CHANNELS-1:0] longPress,
  output logic                anyActive
);

  for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES)
    ) uChannel (
      .clk         (clk),
      .rstN        (rstN),
      .button      (inButton[i]),
      .level       (outButton[i]),
      .pressPulse  (pressPulse[i]),
      .releasePulse(releasePulse[i]),
      .longPress   (longPress[i])
    );
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) anyActive <= 1'b0;
    else       anyActive <= |outButton;
  end

endmodule
